audio_adc_rx: RTL and testbench



---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_lrck_edge.sv | 29 ++
 rtl/audio_adc_rx.sv | 146 ++++++++++++++
 tb/tb_audio_adc_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio codec definitions: receiver state encoding, LRCK channel
// levels and the legal per-channel sample width range used by both the
// ADC receiver and the DAC transmitter.
package audio_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } rx_state_t;

   localparam logic LRCK_LEFT  = 1'b1;
   localparam logic LRCK_RIGHT = 1'b0;

   localparam int AUD_DATA_WIDTH_MIN = 8;
   localparam int AUD_DATA_WIDTH_MAX = 32;

endpackage

// File: rtl/audio_lrck_edge.sv
// LRCK edge detector. Registers the channel-select line and flags any
// change against the registered copy; the new channel is the current level.
import audio_pkg::*;

module audio_lrck_edge (
   input  logic AUD_BCLK,
   input  logic rst,
   input  logic lrck,
   output logic edge_det,
   output logic rise,
   output logic new_channel
);

   logic lrck_q;

   // Previous LRCK level; resets to left so a low LRCK at release reads as a falling edge
   always_ff @(posedge AUD_BCLK or negedge rst) begin
      if (!rst) lrck_q <= LRCK_LEFT;
      else      lrck_q <= lrck;
   end

   // Edge flags are combinational against the registered level
   always_comb begin
      edge_det    = lrck ^ lrck_q;
      rise        = lrck & ~lrck_q;
      new_channel = lrck;
   end

endmodule

// File: rtl/audio_adc_rx.sv
// Audio codec ADC serial receiver. Deserialises AUD_ADCDAT MSB first per
// LRCK channel slot and publishes one stereo pair per frame with a
// one-cycle sample_valid strobe. Truncated channels raise frame_error.
// Optional feature macro: ADC_MONO_MIX_EN adds mono_sample, the halved
// sum of the published left and right samples.
import audio_pkg::*;

module audio_adc_rx #(
   parameter int DATA_WIDTH = 16,
   parameter int BIT_DELAY  = 0
) (
   input  logic                         rst,
   input  logic                         AUD_BCLK,
   input  logic                         AUD_ADCLRCK,
   input  logic                         AUD_ADCDAT,
   output logic signed [DATA_WIDTH-1:0] left_sample,
   output logic signed [DATA_WIDTH-1:0] right_sample,
   output logic                         sample_valid,
   output logic                         frame_error
`ifdef ADC_MONO_MIX_EN
   ,
   output logic signed [DATA_WIDTH-1:0] mono_sample
`endif
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH - 2);

   if (DATA_WIDTH < AUD_DATA_WIDTH_MIN || DATA_WIDTH > AUD_DATA_WIDTH_MAX) begin : g_bad_width
      $error("audio_adc_rx: DATA_WIDTH out of range");
   end
   if (BIT_DELAY != 0 && BIT_DELAY != 1) begin : g_bad_delay
      $error("audio_adc_rx: BIT_DELAY must be 0 or 1");
   end

   rx_state_t                     state;
   logic                          chan;
   logic                          left_ok;
   logic [CW-1:0]                 cnt;
   logic [DATA_WIDTH-2:0]         shift_reg;
   logic signed [DATA_WIDTH-1:0]  hold_left;
   logic signed [DATA_WIDTH-1:0]  word;
   logic                          edge_det, rise, new_channel;
   logic                          start, early, msb_now, shift_now, commit;

`ifdef ADC_MONO_MIX_EN
   // Halved stereo sum at one extra bit so the add cannot overflow
   function automatic logic signed [DATA_WIDTH-1:0] mono_mix(
      input logic signed [DATA_WIDTH-1:0] l,
      input logic signed [DATA_WIDTH-1:0] r
   );
      logic signed [DATA_WIDTH:0] sum;
      logic signed [DATA_WIDTH:0] half;
      sum  = $signed({l[DATA_WIDTH-1], l}) + $signed({r[DATA_WIDTH-1], r});
      half = sum >>> 1;
      return half[DATA_WIDTH-1:0];
   endfunction
`endif

   audio_lrck_edge u_lrck_edge (
      .AUD_BCLK    (AUD_BCLK),
      .rst         (rst),
      .lrck        (AUD_ADCLRCK),
      .edge_det    (edge_det),
      .rise        (rise),
      .new_channel (new_channel)
   );

   // Per-cycle decode: channel start, truncation, MSB load, shift and commit
   always_comb begin
      start     = edge_det && ((state != SYNC) || rise);
      early     = edge_det && ((state == SHIFT) || (state == DELAY));
      msb_now   = (BIT_DELAY == 0) ? start : ((state == DELAY) && !edge_det);
      shift_now = (state == SHIFT) && !edge_det && (cnt != '0);
      commit    = (state == SHIFT) && !edge_det && (cnt == '0);
      word      = {shift_reg, AUD_ADCDAT};
   end

   // Serial shift register and left holding register; pure data, no reset
   always_ff @(posedge AUD_BCLK) begin
      if (msb_now)
         shift_reg <= {{(DATA_WIDTH-2){1'b0}}, AUD_ADCDAT};
      else if (shift_now)
         shift_reg <= {shift_reg[DATA_WIDTH-3:0], AUD_ADCDAT};
      if (commit && chan == LRCK_LEFT)
         hold_left <= word;
   end

   // Framing FSM with registered pair outputs and strobes
   always_ff @(posedge AUD_BCLK or negedge rst) begin
      if (!rst) begin
         state        <= SYNC;
         chan         <= LRCK_LEFT;
         left_ok      <= 1'b0;
         cnt          <= '0;
         left_sample  <= '0;
         right_sample <= '0;
         sample_valid <= 1'b0;
         frame_error  <= 1'b0;
`ifdef ADC_MONO_MIX_EN
         mono_sample  <= '0;
`endif
      end else begin
         sample_valid <= 1'b0;
         frame_error  <= 1'b0;
         if (start) begin
            frame_error <= early;
            if (early) left_ok <= 1'b0;
            chan <= new_channel;
            if (BIT_DELAY != 0) begin
               state <= DELAY;
            end else begin
               state <= SHIFT;
               cnt   <= CNT_LOAD;
            end
         end else begin
            case (state)
               DELAY: begin
                  state <= SHIFT;
                  cnt   <= CNT_LOAD;
               end
               SHIFT: begin
                  if (cnt == '0) begin
                     state <= HOLD;
                     if (chan == LRCK_LEFT) begin
                        left_ok <= 1'b1;
                     end else if (chan == LRCK_RIGHT && left_ok) begin
                        left_sample  <= hold_left;
                        right_sample <= word;
                        sample_valid <= 1'b1;
                        left_ok      <= 1'b0;
`ifdef ADC_MONO_MIX_EN
                        mono_sample  <= mono_mix(hold_left, word);
`endif
                     end
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: one left-justified and one I2S instance
// share the serial lines; each scenario checks the instance it targets.
module tb_audio_adc_rx;

   logic AUD_BCLK = 1'b0;
   logic rst  = 1'b0;
   logic lrck = 1'b0;
   logic dat  = 1'b0;

   logic signed [15:0] l0, r0, l1, r1;
   logic sv0, fe0, sv1, fe1;
`ifdef ADC_MONO_MIX_EN
   logic signed [15:0] m0, m1;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int v0_cnt = 0, fe0_cnt = 0, v0_cyc = 0;
   int v1_cnt = 0, fe1_cnt = 0, v1_cyc = 0;
   logic [15:0] v0_l = '0, v0_r = '0, v1_l = '0, v1_r = '0;

   always #5 AUD_BCLK = ~AUD_BCLK;

   always @(posedge AUD_BCLK) cyc <= cyc + 1;

   audio_adc_rx #(.DATA_WIDTH(16), .BIT_DELAY(0)) u_dut0 (
      .rst(rst), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
      .left_sample(l0), .right_sample(r0), .sample_valid(sv0), .frame_error(fe0)
`ifdef ADC_MONO_MIX_EN
      , .mono_sample(m0)
`endif
   );

   audio_adc_rx #(.DATA_WIDTH(16), .BIT_DELAY(1)) u_dut1 (
      .rst(rst), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
      .left_sample(l1), .right_sample(r1), .sample_valid(sv1), .frame_error(fe1)
`ifdef ADC_MONO_MIX_EN
      , .mono_sample(m1)
`endif
   );

   // Strobe monitor: counts pulses and latches the pair seen with each valid
   always @(negedge AUD_BCLK) begin
      if (sv0) begin v0_cnt++; v0_l = l0; v0_r = r0; v0_cyc = cyc; end
      if (fe0) fe0_cnt++;
      if (sv1) begin v1_cnt++; v1_l = l1; v1_r = r1; v1_cyc = cyc; end
      if (fe1) fe1_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge AUD_BCLK);
      #1;
   endtask

   // One LRCK slot of len cycles; dly shifts the word start; returns LSB posedge index
   task automatic send_slot(input logic l, input logic [15:0] w, input int len,
                            input int dly, input logic pad, output int lsb_cyc);
      lsb_cyc = -1;
      for (int i = 0; i < len; i++) begin
         int idx;
         idx = i - dly;
         @(negedge AUD_BCLK);
         lrck = l;
         if (idx >= 0 && idx < 16) dat = w[15-idx];
         else                      dat = pad;
         if (idx == 15) lsb_cyc = cyc + 1;
      end
      #1;
   endtask

   task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw,
                             input int dly, input logic pad, output int rlsb);
      int dummy;
      send_slot(1'b1, lw, 32, dly, pad, dummy);
      send_slot(1'b0, rw, 32, dly, pad, rlsb);
   endtask

   // Reset with LRCK low, then a short stretch of right-channel bits
   task automatic do_reset();
      @(negedge AUD_BCLK);
      rst = 1'b0; lrck = 1'b0; dat = 1'b0;
      repeat (3) @(negedge AUD_BCLK);
      rst = 1'b1;
      repeat (3) begin
         @(negedge AUD_BCLK);
         lrck = 1'b0; dat = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      @(negedge AUD_BCLK);
      rst = 1'b0;
      #1;
      tests++;
      if ({l0, r0} !== 32'h0) begin fails++; $display("FAIL reset_dut0_samples: got %h/%h want 0000/0000", l0, r0); end
      tests++;
      if ({sv0, fe0} !== 2'b00) begin fails++; $display("FAIL reset_dut0_strobes: got %b%b want 00", sv0, fe0); end
      tests++;
      if ({l1, r1, sv1, fe1} !== 34'h0) begin fails++; $display("FAIL reset_dut1: got %h/%h/%b%b want all zero", l1, r1, sv1, fe1); end
`ifdef ADC_MONO_MIX_EN
      tests++;
      if (m0 !== 16'h0000) begin fails++; $display("FAIL reset_mono: got %h want 0000", m0); end
`endif
   endtask

   task automatic test_nominal();
      int b, bf, rl, d;
      do_reset();
      b = v0_cnt; bf = fe0_cnt;
      send_slot(1'b1, 16'hA5C3, 32, 0, 1'b1, d);
      tests++;
      if (v0_cnt - b !== 0) begin fails++; $display("FAIL nominal_no_valid_after_left: got %0d pulses want 0", v0_cnt - b); end
      send_slot(1'b0, 16'h3C5A, 32, 0, 1'b1, rl);
      wait_cycles(2);
      tests++;
      if (v0_cnt - b !== 1) begin fails++; $display("FAIL nominal_valid_count: got %0d want 1", v0_cnt - b); end
      tests++;
      if (v0_l !== 16'hA5C3) begin fails++; $display("FAIL nominal_left: got %h want a5c3", v0_l); end
      tests++;
      if (v0_r !== 16'h3C5A) begin fails++; $display("FAIL nominal_right: got %h want 3c5a", v0_r); end
      tests++;
      if (v0_cyc !== rl) begin fails++; $display("FAIL nominal_latency: got cycle %0d want %0d", v0_cyc, rl); end
      tests++;
      if (fe0_cnt - bf !== 0) begin fails++; $display("FAIL nominal_frame_error: got %0d pulses want 0", fe0_cnt - bf); end
      tests++;
      if (l0 !== 16'hA5C3 || sv0 !== 1'b0) begin fails++; $display("FAIL nominal_hold: got %h valid=%b want a5c3 valid=0", l0, sv0); end
   endtask

   task automatic test_back_to_back();
      int b, bf, rl;
      b = v0_cnt; bf = fe0_cnt;
      send_frame(16'h8001, 16'h7FFE, 0, 1'b0, rl);
      wait_cycles(1);
      tests++;
      if (v0_l !== 16'h8001 || v0_r !== 16'h7FFE) begin fails++; $display("FAIL b2b_first: got %h/%h want 8001/7ffe", v0_l, v0_r); end
      send_frame(16'h0F0F, 16'hF0F0, 0, 1'b1, rl);
      wait_cycles(1);
      tests++;
      if (v0_l !== 16'h0F0F || v0_r !== 16'hF0F0) begin fails++; $display("FAIL b2b_second: got %h/%h want 0f0f/f0f0", v0_l, v0_r); end
      tests++;
      if (v0_cnt - b !== 2 || fe0_cnt - bf !== 0) begin fails++; $display("FAIL b2b_counts: got valid=%0d err=%0d want 2/0", v0_cnt - b, fe0_cnt - bf); end
   endtask

   task automatic test_i2s();
      int b, bf, rl;
      do_reset();
      b = v1_cnt; bf = fe1_cnt;
      send_frame(16'hA5C3, 16'h3C5A, 1, 1'b1, rl);
      wait_cycles(2);
      tests++;
      if (v1_cnt - b !== 1) begin fails++; $display("FAIL i2s_valid_count: got %0d want 1", v1_cnt - b); end
      tests++;
      if (v1_l !== 16'hA5C3 || v1_r !== 16'h3C5A) begin fails++; $display("FAIL i2s_pair: got %h/%h want a5c3/3c5a", v1_l, v1_r); end
      tests++;
      if (v1_cyc !== rl) begin fails++; $display("FAIL i2s_latency: got cycle %0d want %0d", v1_cyc, rl); end
      tests++;
      if (fe1_cnt - bf !== 0) begin fails++; $display("FAIL i2s_frame_error: got %0d want 0", fe1_cnt - bf); end
   endtask

   task automatic test_i2s_without_delay();
      int b, rl;
      do_reset();
      b = v1_cnt;
      send_frame(16'hA5C3, 16'h3C5A, 0, 1'b0, rl);
      wait_cycles(2);
      tests++;
      if (v1_cnt - b !== 1) begin fails++; $display("FAIL nodelay_valid_count: got %0d want 1", v1_cnt - b); end
      tests++;
      if (v1_l !== 16'h4B86 || v1_r !== 16'h78B4) begin fails++; $display("FAIL nodelay_pair: got %h/%h want 4b86/78b4", v1_l, v1_r); end
      tests++;
      if (v1_cyc !== rl + 1) begin fails++; $display("FAIL nodelay_latency: got cycle %0d want %0d", v1_cyc, rl + 1); end
   endtask

   task automatic test_startup_mid_right();
      int b, bf, rl, d;
      do_reset();
      b = v0_cnt; bf = fe0_cnt;
      send_slot(1'b0, 16'hFFFF, 8, 0, 1'b1, d);
      send_slot(1'b1, 16'h1234, 32, 0, 1'b1, d);
      tests++;
      if (v0_cnt - b !== 0) begin fails++; $display("FAIL startup_early_valid: got %0d want 0", v0_cnt - b); end
      send_slot(1'b0, 16'hFEDC, 32, 0, 1'b1, rl);
      wait_cycles(1);
      tests++;
      if (v0_cnt - b !== 1 || v0_l !== 16'h1234 || v0_r !== 16'hFEDC) begin
         fails++; $display("FAIL startup_pair: got n=%0d %h/%h want n=1 1234/fedc", v0_cnt - b, v0_l, v0_r);
      end
      tests++;
      if (fe0_cnt - bf !== 0) begin fails++; $display("FAIL startup_frame_error: got %0d want 0", fe0_cnt - bf); end
   endtask

   task automatic test_short_channel();
      int b, bf, rl, d;
      do_reset();
      send_frame(16'h1111, 16'h2222, 0, 1'b1, rl);
      wait_cycles(1);
      b = v0_cnt; bf = fe0_cnt;
      send_slot(1'b1, 16'hABCD, 10, 0, 1'b1, d);
      send_slot(1'b0, 16'h5555, 32, 0, 1'b1, d);
      wait_cycles(1);
      tests++;
      if (fe0_cnt - bf !== 1) begin fails++; $display("FAIL short_frame_error: got %0d pulses want 1", fe0_cnt - bf); end
      tests++;
      if (v0_cnt - b !== 0) begin fails++; $display("FAIL short_no_valid: got %0d want 0", v0_cnt - b); end
      tests++;
      if (l0 !== 16'h1111 || r0 !== 16'h2222) begin fails++; $display("FAIL short_hold: got %h/%h want 1111/2222", l0, r0); end
      send_frame(16'h0F0F, 16'hF0F0, 0, 1'b1, rl);
      wait_cycles(2);
      tests++;
      if (v0_cnt - b !== 1 || l0 !== 16'h0F0F || r0 !== 16'hF0F0) begin
         fails++; $display("FAIL short_recover: got n=%0d %h/%h want n=1 0f0f/f0f0", v0_cnt - b, l0, r0);
      end
      tests++;
      if (fe0_cnt - bf !== 1) begin fails++; $display("FAIL short_recover_error: got %0d want 1", fe0_cnt - bf); end
   endtask

   task automatic test_reset_mid_frame();
      int b, bf, rl, d;
      do_reset();
      send_frame(16'hA5C3, 16'h3C5A, 0, 1'b1, rl);
      wait_cycles(1);
      send_slot(1'b1, 16'h1357, 32, 0, 1'b1, d);
      send_slot(1'b0, 16'h2468, 8, 0, 1'b1, d);
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({l0, r0, sv0} !== 33'h0) begin fails++; $display("FAIL midreset_clear: got %h/%h valid=%b want 0000/0000 valid=0", l0, r0, sv0); end
      repeat (2) @(negedge AUD_BCLK);
      rst = 1'b1;
      repeat (3) begin @(negedge AUD_BCLK); lrck = 1'b0; dat = 1'b1; end
      #1;
      b = v0_cnt; bf = fe0_cnt;
      send_frame(16'hACE1, 16'h1ACE, 0, 1'b1, rl);
      wait_cycles(2);
      tests++;
      if (v0_cnt - b !== 1 || l0 !== 16'hACE1 || r0 !== 16'h1ACE) begin
         fails++; $display("FAIL midreset_recover: got n=%0d %h/%h want n=1 ace1/1ace", v0_cnt - b, l0, r0);
      end
      tests++;
      if (fe0_cnt - bf !== 0) begin fails++; $display("FAIL midreset_frame_error: got %0d want 0", fe0_cnt - bf); end
   endtask

`ifdef ADC_MONO_MIX_EN
   task automatic test_mono();
      int rl;
      do_reset();
      send_frame(16'h7FFF, 16'h0001, 0, 1'b1, rl);
      wait_cycles(1);
      tests++;
      if (m0 !== 16'h4000) begin fails++; $display("FAIL mono_7fff_0001: got %h want 4000", m0); end
      send_frame(16'h8000, 16'h8000, 0, 1'b1, rl);
      wait_cycles(1);
      tests++;
      if (m0 !== 16'h8000) begin fails++; $display("FAIL mono_8000_8000: got %h want 8000", m0); end
      send_frame(16'hFFFF, 16'h0001, 0, 1'b1, rl);
      wait_cycles(1);
      tests++;
      if (m0 !== 16'h0000) begin fails++; $display("FAIL mono_ffff_0001: got %h want 0000", m0); end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_i2s();
      test_i2s_without_delay();
      test_startup_mid_right();
      test_short_channel();
      test_reset_mid_frame();
`ifdef ADC_MONO_MIX_EN
      test_mono();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
